// File: rtl/iterative_thinner.sv
// rtl/iterative_thinner.sv - multi-pass 3x3 binary morphology (thinning, erosion, dilation) over a buffered frame
// Ping-pong frame buffers give every pass a frozen source image while its results land in the other half.
module iterative_thinner #(
   parameter int HORIZONTAL_COUNT = 320,
   parameter int VERTICAL_COUNT   = 180,
   parameter int MAX_PASSES       = 16,
   parameter int MODE             = 0,
   localparam int HWIDTH = $clog2(HORIZONTAL_COUNT),
   localparam int VWIDTH = $clog2(VERTICAL_COUNT)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [HWIDTH-1:0] hcount_in,
   input  logic [VWIDTH-1:0] vcount_in,
   input  logic              pixel_in,
   input  logic              pixel_valid_in,
   output logic              pixel_out,
   output logic [HWIDTH-1:0] hcount_out,
   output logic [VWIDTH-1:0] vcount_out,
   output logic              pixel_valid_out,
   output logic              busy,
   output logic [7:0]        passes_out,
   output logic              converged_out,
   output logic              frame_done_out,
   output logic              drop_out
);
   localparam int NPIX    = HORIZONTAL_COUNT * VERTICAL_COUNT;
   localparam int AWIDTH  = $clog2(NPIX);
   // Read address to writeback in cycles: window capture stage(s), then compute-and-write.
   localparam int LATENCY = 2;

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_OUTPUT} state_t;

   typedef struct packed {
      logic              valid;
      logic              last;
      logic              border;
      logic [AWIDTH-1:0] addr;
      logic [8:0]        win;
   } pipe_t;

   state_t            state_q, state_d;
   logic [NPIX-1:0]   fb_q [2];
   logic              fb_we, fb_wsel, fb_wdata;
   logic [AWIDTH-1:0] fb_waddr;

   logic              sel_q, sel_d, parity_q, parity_d, changed_q, changed_d;
   logic              prev_quiet_q, prev_quiet_d, conv_pend_q, conv_pend_d;
   logic [7:0]        pass_cnt_q, pass_cnt_d, passes_q, passes_d;
   logic              converged_q, converged_d, frame_done_q, frame_done_d, drop_q, drop_d;
   logic              scan_act_q, scan_act_d;
   logic [VWIDTH-1:0] scan_row_q, scan_row_d, out_row_q, out_row_d;
   logic [HWIDTH-1:0] scan_col_q, scan_col_d, out_col_q, out_col_d;
   logic [AWIDTH-1:0] scan_addr_q, scan_addr_d, out_addr_q, out_addr_d;
   pipe_t             pipe_q [LATENCY-1];
   pipe_t             pipe_d [LATENCY-1];

   pipe_t             wb;
   logic [8:0]        win_rd;
   logic              interior;
   logic              in_range, in_last;
   logic [AWIDTH-1:0] in_addr;
   logic [8:0]        p;
   logic [3:0]        b_cnt, a_cnt;
   logic              side_ok, del, result;
   logic              changed_now, conv_hit;
   logic [7:0]        cnt_next;

   assign in_range = (int'(hcount_in) < HORIZONTAL_COUNT) && (int'(vcount_in) < VERTICAL_COUNT);
   assign in_last  = (int'(hcount_in) == HORIZONTAL_COUNT-1) && (int'(vcount_in) == VERTICAL_COUNT-1);
   assign in_addr  = AWIDTH'(int'(vcount_in) * HORIZONTAL_COUNT + int'(hcount_in));
   assign wb       = pipe_q[LATENCY-2];

   // Window bit index is row*3+col within the 3x3 neighbourhood; border pixels only need their centre.
   always_comb begin
      win_rd   = '0;
      interior = (scan_row_q != '0) && (int'(scan_row_q) != VERTICAL_COUNT-1) &&
                 (scan_col_q != '0) && (int'(scan_col_q) != HORIZONTAL_COUNT-1);
      win_rd[4] = fb_q[sel_q][scan_addr_q];
      if (interior) begin
         for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
               win_rd[dr*3+dc] = fb_q[sel_q][AWIDTH'(int'(scan_addr_q) + (dr-1)*HORIZONTAL_COUNT + dc - 1)];
            end
         end
      end
   end

   // p[0..7] = P2..P9 clockwise from north, p[8] repeats P2 to close the transition ring.
   always_comb begin
      p = {wb.win[1], wb.win[0], wb.win[3], wb.win[6], wb.win[7], wb.win[8], wb.win[5], wb.win[2], wb.win[1]};
      b_cnt = '0;
      a_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         b_cnt = b_cnt + {3'b000, p[i]};
         a_cnt = a_cnt + {3'b000, ~p[i] & p[i+1]};
      end
      if (parity_q) begin
         side_ok = !(p[0] & p[2] & p[6]) && !(p[0] & p[4] & p[6]);
      end else begin
         side_ok = !(p[0] & p[2] & p[4]) && !(p[2] & p[4] & p[6]);
      end
      del = wb.win[4] && (b_cnt >= 4'd2) && (b_cnt <= 4'd6) && (a_cnt == 4'd1) && side_ok;
      case (MODE)
         1:       result = &wb.win;
         2:       result = |wb.win;
         default: result = wb.win[4] & ~del;
      endcase
      if (wb.border) begin
         result = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      parity_d     = parity_q;
      changed_d    = changed_q;
      prev_quiet_d = prev_quiet_q;
      conv_pend_d  = conv_pend_q;
      pass_cnt_d   = pass_cnt_q;
      passes_d     = passes_q;
      converged_d  = converged_q;
      scan_act_d   = scan_act_q;
      scan_row_d   = scan_row_q;
      scan_col_d   = scan_col_q;
      scan_addr_d  = scan_addr_q;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
      out_addr_d   = out_addr_q;
      for (int i = 1; i < LATENCY-1; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      pipe_d[0]    = '0;
      fb_we        = 1'b0;
      fb_wsel      = sel_q;
      fb_waddr     = '0;
      fb_wdata     = 1'b0;
      frame_done_d = 1'b0;
      drop_d       = pixel_valid_in && (state_q != S_IDLE);
      changed_now  = changed_q;
      conv_hit     = 1'b0;
      cnt_next     = pass_cnt_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (pixel_valid_in && in_range) begin
               fb_we    = 1'b1;
               fb_waddr = in_addr;
               fb_wdata = pixel_in;
               if (in_last) begin
                  state_d      = S_PASS;
                  pass_cnt_d   = '0;
                  parity_d     = 1'b0;
                  changed_d    = 1'b0;
                  prev_quiet_d = 1'b0;
                  scan_act_d   = 1'b1;
                  scan_row_d   = '0;
                  scan_col_d   = '0;
                  scan_addr_d  = '0;
               end
            end
         end
         S_PASS: begin
            if (scan_act_q) begin
               pipe_d[0].valid  = 1'b1;
               pipe_d[0].last   = (scan_addr_q == AWIDTH'(NPIX-1));
               pipe_d[0].border = !interior;
               pipe_d[0].addr   = scan_addr_q;
               pipe_d[0].win    = win_rd;
               scan_addr_d = scan_addr_q + AWIDTH'(1);
               if (scan_col_q == HWIDTH'(HORIZONTAL_COUNT-1)) begin
                  scan_col_d = '0;
                  scan_row_d = scan_row_q + VWIDTH'(1);
               end else begin
                  scan_col_d = scan_col_q + HWIDTH'(1);
               end
               if (pipe_d[0].last) begin
                  scan_act_d = 1'b0;
               end
            end
            if (wb.valid) begin
               fb_we       = 1'b1;
               fb_wsel     = ~sel_q;
               fb_waddr    = wb.addr;
               fb_wdata    = result;
               changed_now = changed_q | (result != wb.win[4]);
               changed_d   = changed_now;
               if (wb.last) begin
                  // Thinning alternates two sub-iterations, so it needs two quiet passes in a row.
                  conv_hit   = (MODE == 0) ? (!changed_now && prev_quiet_q) : !changed_now;
                  pass_cnt_d = cnt_next;
                  parity_d   = ~parity_q;
                  sel_d      = ~sel_q;
                  if (conv_hit || (cnt_next == 8'(MAX_PASSES))) begin
                     state_d     = S_OUTPUT;
                     conv_pend_d = conv_hit;
                     out_row_d   = '0;
                     out_col_d   = '0;
                     out_addr_d  = '0;
                  end else begin
                     changed_d    = 1'b0;
                     prev_quiet_d = !changed_now;
                     scan_act_d   = 1'b1;
                     scan_row_d   = '0;
                     scan_col_d   = '0;
                     scan_addr_d  = '0;
                  end
               end
            end
         end
         S_OUTPUT: begin
            out_addr_d = out_addr_q + AWIDTH'(1);
            if (out_col_q == HWIDTH'(HORIZONTAL_COUNT-1)) begin
               out_col_d = '0;
               out_row_d = out_row_q + VWIDTH'(1);
            end else begin
               out_col_d = out_col_q + HWIDTH'(1);
            end
            if (out_addr_q == AWIDTH'(NPIX-1)) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
               passes_d     = pass_cnt_q;
               converged_d  = conv_pend_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= S_IDLE;
         sel_q        <= 1'b0;
         parity_q     <= 1'b0;
         changed_q    <= 1'b0;
         prev_quiet_q <= 1'b0;
         conv_pend_q  <= 1'b0;
         pass_cnt_q   <= '0;
         passes_q     <= '0;
         converged_q  <= 1'b0;
         frame_done_q <= 1'b0;
         drop_q       <= 1'b0;
         scan_act_q   <= 1'b0;
         scan_row_q   <= '0;
         scan_col_q   <= '0;
         scan_addr_q  <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_addr_q   <= '0;
         for (int i = 0; i < LATENCY-1; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         parity_q     <= parity_d;
         changed_q    <= changed_d;
         prev_quiet_q <= prev_quiet_d;
         conv_pend_q  <= conv_pend_d;
         pass_cnt_q   <= pass_cnt_d;
         passes_q     <= passes_d;
         converged_q  <= converged_d;
         frame_done_q <= frame_done_d;
         drop_q       <= drop_d;
         scan_act_q   <= scan_act_d;
         scan_row_q   <= scan_row_d;
         scan_col_q   <= scan_col_d;
         scan_addr_q  <= scan_addr_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         out_addr_q   <= out_addr_d;
         for (int i = 0; i < LATENCY-1; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   // Image storage carries no reset; every frame rewrites it completely before use.
   always_ff @(posedge clk_in) begin
      if (fb_we) begin
         fb_q[fb_wsel][fb_waddr] <= fb_wdata;
      end
   end

   assign pixel_valid_out = (state_q == S_OUTPUT);
   assign pixel_out       = pixel_valid_out ? fb_q[sel_q][out_addr_q] : 1'b0;
   assign hcount_out      = pixel_valid_out ? out_col_q : '0;
   assign vcount_out      = pixel_valid_out ? out_row_q : '0;
   assign busy            = (state_q == S_PASS) || (state_q == S_OUTPUT);
   assign passes_out      = passes_q;
   assign converged_out   = converged_q;
   assign frame_done_out  = frame_done_q;
   assign drop_out        = drop_q;
endmodule

// File: tb/tb_iterative_thinner.sv
// tb/tb_iterative_thinner.sv - directed frame tests for iterative_thinner in all three modes
// Image vectors hold row r in bits [8r+7:8r], column h at bit h.
module tb_iterative_thinner;
   localparam int H = 8;
   localparam int V = 6;
   localparam int N = H * V;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] hc_in = '0;
   logic [2:0] vc_in = '0;
   logic       pix_in = 1'b0;
   logic [2:0] vin = '0;

   logic       pix_out [3];
   logic [2:0] hc_out [3];
   logic [2:0] vc_out [3];
   logic       pv_out [3];
   logic       busy [3];
   logic [7:0] passes [3];
   logic       conv [3];
   logic       fd [3];
   logic       drop [3];

   always #5 clk = ~clk;

   iterative_thinner #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .MAX_PASSES(16), .MODE(0)) u_thin (
      .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc_in), .vcount_in(vc_in), .pixel_in(pix_in),
      .pixel_valid_in(vin[0]), .pixel_out(pix_out[0]), .hcount_out(hc_out[0]), .vcount_out(vc_out[0]),
      .pixel_valid_out(pv_out[0]), .busy(busy[0]), .passes_out(passes[0]), .converged_out(conv[0]),
      .frame_done_out(fd[0]), .drop_out(drop[0]));

   iterative_thinner #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .MAX_PASSES(2), .MODE(1)) u_erode (
      .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc_in), .vcount_in(vc_in), .pixel_in(pix_in),
      .pixel_valid_in(vin[1]), .pixel_out(pix_out[1]), .hcount_out(hc_out[1]), .vcount_out(vc_out[1]),
      .pixel_valid_out(pv_out[1]), .busy(busy[1]), .passes_out(passes[1]), .converged_out(conv[1]),
      .frame_done_out(fd[1]), .drop_out(drop[1]));

   iterative_thinner #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .MAX_PASSES(1), .MODE(2)) u_dilate (
      .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc_in), .vcount_in(vc_in), .pixel_in(pix_in),
      .pixel_valid_in(vin[2]), .pixel_out(pix_out[2]), .hcount_out(hc_out[2]), .vcount_out(vc_out[2]),
      .pixel_valid_out(pv_out[2]), .busy(busy[2]), .passes_out(passes[2]), .converged_out(conv[2]),
      .frame_done_out(fd[2]), .drop_out(drop[2]));

   int         vcnt [3];
   int         fdcnt [3];
   int         dropcnt [3];
   int         ordererr [3];
   int         idleerr [3];
   int         risecnt [3];
   int         exp_idx [3];
   logic       prev_pv [3];
   logic [N-1:0] got [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         vcnt[k] = 0; fdcnt[k] = 0; dropcnt[k] = 0; ordererr[k] = 0;
         idleerr[k] = 0; risecnt[k] = 0; exp_idx[k] = 0; prev_pv[k] = 1'b0; got[k] = '0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) exp_idx[k] = 0;
         if (pv_out[k] === 1'b1) begin
            if (!prev_pv[k]) risecnt[k]++;
            if (int'(vc_out[k]) * H + int'(hc_out[k]) != exp_idx[k]) ordererr[k]++;
            if (int'(vc_out[k]) * H + int'(hc_out[k]) < N) got[k][int'(vc_out[k]) * H + int'(hc_out[k])] = pix_out[k];
            exp_idx[k]++;
            vcnt[k]++;
         end else if (pix_out[k] !== 1'b0 || hc_out[k] !== 3'd0 || vc_out[k] !== 3'd0) begin
            idleerr[k]++;
         end
         prev_pv[k] = pv_out[k];
         if (fd[k] === 1'b1) begin
            fdcnt[k]++;
            exp_idx[k] = 0;
         end
         if (drop[k] === 1'b1) dropcnt[k]++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          k;
      logic [N-1:0] img;
      logic [N-1:0] exp;
      int          passes;
      bit          conv;
      bit          extra;
   } vec_t;

   vec_t tbl [4];

   task automatic send_frame(input int k, input logic [N-1:0] img, input bit extra);
      for (int v = 0; v < V; v++) begin
         for (int h = 0; h < H; h++) begin
            if (extra && v == V-1 && h == H-1) begin
               hc_in = 3'd7; vc_in = 3'd6; pix_in = 1'b1; vin = 3'(1 << k);
               @(posedge clk); #1;
               hc_in = 3'd7; vc_in = 3'd7; pix_in = 1'b1;
               @(posedge clk); #1;
            end
            hc_in = 3'(h); vc_in = 3'(v); pix_in = img[v*H+h]; vin = 3'(1 << k);
            @(posedge clk); #1;
         end
      end
      vin = '0; pix_in = 1'b0; hc_in = '0; vc_in = '0;
   endtask

   task automatic wait_done(input int k, output bit ok);
      int n;
      n = 0;
      ok = 1'b0;
      while (n < 3000 && !ok) begin
         @(negedge clk);
         if (fd[k] === 1'b1) ok = 1'b1;
         n++;
      end
   endtask

   task automatic run_frame(input string tag, input vec_t t, input int ninject);
      int b_v, b_fd, b_rise, b_ord, b_idle, b_drop;
      bit ok;
      b_v = vcnt[t.k]; b_fd = fdcnt[t.k]; b_rise = risecnt[t.k];
      b_ord = ordererr[t.k]; b_idle = idleerr[t.k]; b_drop = dropcnt[t.k];
      send_frame(t.k, t.img, t.extra);
      if (ninject > 0) begin
         repeat (3) @(posedge clk);
         #1;
         chk({tag, "_busy"}, 64'(busy[t.k]), 64'd1);
         for (int i = 0; i < ninject; i++) begin
            hc_in = 3'd7; vc_in = 3'd5; pix_in = 1'b1; vin = 3'(1 << t.k);
            @(posedge clk); #1;
            vin = '0;
            @(posedge clk); #1;
         end
         pix_in = 1'b0; hc_in = '0; vc_in = '0;
      end
      wait_done(t.k, ok);
      chk({tag, "_done_in_time"}, 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      chk({tag, "_valid_count"}, 64'(vcnt[t.k] - b_v), 64'(N));
      chk({tag, "_image"}, 64'(got[t.k]), 64'(t.exp));
      chk({tag, "_passes"}, 64'(passes[t.k]), 64'(t.passes));
      chk({tag, "_converged"}, 64'(conv[t.k]), 64'(t.conv));
      chk({tag, "_frame_done_pulses"}, 64'(fdcnt[t.k] - b_fd), 64'd1);
      chk({tag, "_valid_bursts"}, 64'(risecnt[t.k] - b_rise), 64'd1);
      chk({tag, "_raster_order_errs"}, 64'(ordererr[t.k] - b_ord), 64'd0);
      chk({tag, "_idle_output_errs"}, 64'(idleerr[t.k] - b_idle), 64'd0);
      chk({tag, "_drops"}, 64'(dropcnt[t.k] - b_drop), 64'(ninject));
   endtask

   initial begin
      int b_fd;
      tbl[0] = '{0, 48'h00003C3C3C00, 48'h000000080000, 4, 1'b1, 1'b0};
      tbl[1] = '{1, 48'hFFFFFFFFFFFF, 48'h00003C3C0000, 2, 1'b0, 1'b0};
      tbl[2] = '{2, 48'h000010000000, 48'h003838380000, 1, 1'b0, 1'b0};
      tbl[3] = '{0, 48'h000000000000, 48'h000000000000, 2, 1'b1, 1'b1};

      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_outputs_%0d", k),
             64'({busy[k], pv_out[k], pix_out[k], hc_out[k], vc_out[k], passes[k], conv[k], fd[k], drop[k]}), 64'd0);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) begin
         run_frame($sformatf("frame%0d", i), tbl[i], 0);
      end

      run_frame("drop", tbl[0], 5);

      b_fd = fdcnt[0];
      send_frame(0, tbl[0].img, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_busy_before", 64'(busy[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy_now", 64'(busy[0]), 64'd0);
      chk("abort_outputs_now", 64'({pv_out[0], passes[0], conv[0], fd[0]}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      chk("abort_no_frame_done", 64'(fdcnt[0] - b_fd), 64'd0);
      chk("abort_idle", 64'(busy[0]), 64'd0);
      @(posedge clk); #1;
      run_frame("after_abort", tbl[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
